tf_norm_pack: RTL and testbench
===============================

TF_NORM_PACK -- requirements
Module: tf_norm_pack

Interface
REQ-001 The block SHALL have parameter BITS_IN, default 95, meaning total packed output bus width.
REQ-002 The block SHALL have parameter VEC_LEN, default 16, meaning samples per norm vector (1..255).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning begin a new vector.
REQ-006 The block SHALL have port wt_in, input, 54, meaning signed Q17.36 weight, captured with start.
REQ-007 The block SHALL have port din_valid, input, 1, meaning din carries a sample this cycle.
REQ-008 The block SHALL have port din, input, 18, meaning signed Q1.16 sample.
REQ-009 The block SHALL have port OBUS, output, BITS_IN, meaning the packed result: [40:0] unsigned norm (sum of squares, Q9.32), [94:41] weight.
REQ-010 The block SHALL have port obus_valid, output, 1, meaning a one-cycle pulse when OBUS holds a new result.
REQ-011 The block SHALL have port busy, output, 1, meaning high whenever state is not IDLE.

Function
REQ-012 The state machine SHALL have states IDLE, ACC and DRAIN.
REQ-013 In IDLE with start=1, the block SHALL latch wt_in, clear the accumulator and sample count, and go to ACC.
REQ-014 In ACC, each cycle with din_valid=1 SHALL register din*din as a 36-bit signed product, increment count and add the previous registered product to the accumulator.
REQ-015 The sample accepted with count=VEC_LEN-1 SHALL move the state to DRAIN.
REQ-016 In DRAIN, the block SHALL add the final product, write OBUS[40:0]=accumulator and OBUS[94:41]=latched weight, pulse obus_valid, and return to IDLE.
REQ-017 Latency SHALL be exactly 2 cycles: obus_valid is high in the cycle that starts two edges after the edge capturing the last sample.
REQ-018 The norm SHALL be computed as the sum of the squared Q2.32 products (non-negative, at most 35 significant bits) in a 41-bit unsigned accumulator.
REQ-019 If an addition would exceed 2^41-1, the accumulator SHALL saturate at 41'h1FF_FFFF_FFFF and stay saturated until the next start.
REQ-020 OBUS SHALL hold its last value between results; obus_valid SHALL be high for exactly one cycle per vector.
REQ-021 din_valid SHALL be ignored in IDLE and DRAIN.
REQ-022 start SHALL be ignored when not in IDLE.
REQ-023 If start and din_valid are both high in IDLE, that din SHALL NOT be counted.
REQ-024 Gaps (din_valid=0) in ACC SHALL stall the count without affecting the result.

Reset
REQ-025 rst=1 at an edge SHALL set state IDLE, accumulator 0, count 0, product register 0, OBUS 0, obus_valid 0 and latched weight 0.
REQ-026 rst SHALL take priority over start and din_valid.
REQ-027 rst asserted mid-vector SHALL abort the vector, and no obus_valid SHALL be produced for it.

Verification
REQ-028 Basic: VEC_LEN=16, start with wt_in=54'h1, then 16 consecutive din=18'h10000 (1.0) -> obus_valid 2 cycles after the last sample, OBUS[40:0]=41'h10_0000_0000, OBUS[94:41]=1.
REQ-029 Negative extremes: VEC_LEN=4, din=18'h20000 (-2.0) x4 -> norm=41'h10_0000_0000.
REQ-030 Gapped input: 16 samples of 18'h08000 (0.5) with din_valid toggling every other cycle -> norm=41'h4_0000_0000, a single obus_valid pulse, and busy high throughout.
REQ-031 Saturation: VEC_LEN=128, din=18'h20000 x128 -> norm=41'h1FF_FFFF_FFFF.
REQ-032 Reset and ignored inputs: rst after the 5th sample -> no obus_valid and OBUS=0; start during ACC and din_valid during IDLE change nothing.

Source files
------------

// File: rtl/tf_norm_pack.sv
// Streaming sum-of-squares norm over VEC_LEN signed Q1.16 samples. The result
// is packed with the weight latched at start: OBUS = {weight[53:0], norm[40:0]}.
module tf_norm_pack #(
  parameter int BITS_IN = 95,
  parameter int VEC_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [53:0]        wt_in,
  input  logic               din_valid,
  input  logic [17:0]        din,
  output logic [BITS_IN-1:0] OBUS,
  output logic               obus_valid,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

  localparam logic [7:0] LAST_CNT = 8'(VEC_LEN - 1);

  state_t              r_state;
  state_t              w_next;
  logic [53:0]         r_wt;
  logic [40:0]         r_acc;
  logic [7:0]          r_count;
  logic signed [35:0]  r_prod;
  logic                r_drain_ph;
  logic [BITS_IN-1:0]  r_obus;
  logic                r_obus_valid;

  logic signed [35:0]  w_prod;
  logic [41:0]         w_sum;
  logic [40:0]         w_acc_next;
  logic                w_last;

  assign w_prod = $signed(din) * $signed(din);

  // Squares are never negative, so the product register is added zero-extended;
  // the carry out of the 42-bit sum marks overflow and pins the accumulator.
  assign w_sum      = {6'b0, r_prod} + {1'b0, r_acc};
  assign w_acc_next = w_sum[41] ? '1 : w_sum[40:0];
  assign w_last     = din_valid && (r_count == LAST_CNT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_next = S_ACC;
      S_ACC:   if (w_last)     w_next = S_DRAIN;
      S_DRAIN: if (r_drain_ph) w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // DRAIN spans two cycles: fold in the last product, then publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wt         <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_prod       <= '0;
      r_drain_ph   <= 1'b0;
      r_obus       <= '0;
      r_obus_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_obus_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wt       <= wt_in;
            r_acc      <= '0;
            r_count    <= '0;
            r_prod     <= '0;
            r_drain_ph <= 1'b0;
          end
        end
        S_ACC: begin
          if (din_valid) begin
            r_prod  <= w_prod;
            r_count <= r_count + 8'd1;
            r_acc   <= w_acc_next;
          end
        end
        S_DRAIN: begin
          if (!r_drain_ph) begin
            r_acc      <= w_acc_next;
            r_drain_ph <= 1'b1;
          end else begin
            r_obus       <= BITS_IN'({r_wt, r_acc});
            r_obus_valid <= 1'b1;
            r_drain_ph   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign OBUS       = r_obus;
  assign obus_valid = r_obus_valid;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tf_norm_pack.sv
// Bench for tf_norm_pack: three instances (VEC_LEN 16, 4, 128) share data
// inputs; expected packed results are queued at stimulus time and popped on obus_valid.
module tb_tf_norm_pack;

  localparam logic [40:0] NORM_MAX = 41'h1FF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [53:0] wt_in;
  logic        din_valid;
  logic [17:0] din;
  logic        st   [3];
  logic [94:0] obus [3];
  logic        ov   [3];
  logic        bsy  [3];

  typedef struct {
    int          id;
    logic [94:0] obus;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  logic [94:0] last_exp [3];
  logic [17:0] smp [256];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tf_norm_pack #(.BITS_IN(95), .VEC_LEN(16)) u16 (
    .clk(clk), .rst(rst), .start(st[0]), .wt_in(wt_in), .din_valid(din_valid),
    .din(din), .OBUS(obus[0]), .obus_valid(ov[0]), .busy(bsy[0]));
  tf_norm_pack #(.BITS_IN(95), .VEC_LEN(4)) u4 (
    .clk(clk), .rst(rst), .start(st[1]), .wt_in(wt_in), .din_valid(din_valid),
    .din(din), .OBUS(obus[1]), .obus_valid(ov[1]), .busy(bsy[1]));
  tf_norm_pack #(.BITS_IN(95), .VEC_LEN(128)) u128 (
    .clk(clk), .rst(rst), .start(st[2]), .wt_in(wt_in), .din_valid(din_valid),
    .din(din), .OBUS(obus[2]), .obus_valid(ov[2]), .busy(bsy[2]));

  // Output monitor: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL valid_unexpected dut=%0d got obus=%h want no pulse", i, obus[i]);
        end else begin
          m_e = sb.pop_front();
          if (m_e.id != i || obus[i] !== m_e.obus) begin
            bad++;
            $display("FAIL result dut=%0d got %h want dut=%0d %h", i, obus[i], m_e.id, m_e.obus);
          end
          total++;
          if (cyc !== m_e.due) begin
            bad++;
            $display("FAIL latency dut=%0d got edge %0d want edge %0d", i, cyc, m_e.due);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] norm_model(input int n);
    longint acc = 0;
    longint s;
    for (int i = 0; i < n; i++) begin
      s = $signed(smp[i]);
      acc += s * s;
    end
    if (acc > longint'(NORM_MAX)) return NORM_MAX;
    return acc[40:0];
  endfunction

  // junk: din_valid in IDLE, din_valid with start, and a second start mid-vector.
  task automatic run_vector(input int id, input logic [53:0] wt, input int n,
                            input bit gap, input bit junk);
    exp_t e;
    if (junk) begin
      din = 18'h1FFFF; din_valid = 1'b1;
      repeat (3) tick();
    end
    st[id] = 1'b1; wt_in = wt;
    din_valid = junk; din = 18'h1FFFF;
    tick();
    st[id] = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        din_valid = 1'b0; din = 18'h1FFFF;
        tick();
        total++;
        if (bsy[id] !== 1'b1) begin
          bad++;
          $display("FAIL busy_gap dut=%0d got %b want 1", id, bsy[id]);
        end
      end
      if (junk && i == n / 2) begin
        st[id] = 1'b1; wt_in = ~wt;
      end
      din = smp[i]; din_valid = 1'b1;
      tick();
      st[id] = 1'b0; wt_in = wt;
      total++;
      if (bsy[id] !== 1'b1) begin
        bad++;
        $display("FAIL busy_acc dut=%0d got %b want 1", id, bsy[id]);
      end
    end
    din_valid = 1'b0;
    e.id   = id;
    e.obus = {wt, norm_model(n)};
    e.due  = cyc + 2;
    last_exp[id] = e.obus;
    sb.push_back(e);
    for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL timeout dut=%0d got no obus_valid want pulse", id);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wt_in = '0; din_valid = 1'b0; din = '0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (obus[i] !== 95'd0) begin bad++; $display("FAIL reset_obus dut=%0d got %h want 0", i, obus[i]); end
      if (ov[i] !== 1'b0)    begin bad++; $display("FAIL reset_valid dut=%0d got %b want 0", i, ov[i]); end
      if (bsy[i] !== 1'b0)   begin bad++; $display("FAIL reset_busy dut=%0d got %b want 0", i, bsy[i]); end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) smp[i] = 18'h10000;
    run_vector(0, 54'h1, 16, 1'b0, 1'b0);
    total++;
    if (obus[0] !== {54'h1, 41'h10_0000_0000}) begin
      bad++; $display("FAIL basic_const got %h want %h", obus[0], {54'h1, 41'h10_0000_0000});
    end
  endtask

  task automatic test_neg_extreme();
    for (int i = 0; i < 4; i++) smp[i] = 18'h20000;
    run_vector(1, 54'h3F_FFFF_FFFF_FFFF, 4, 1'b0, 1'b0);
    total++;
    if (obus[1][40:0] !== 41'h10_0000_0000) begin
      bad++; $display("FAIL neg_const got %h want %h", obus[1][40:0], 41'h10_0000_0000);
    end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 16; i++) smp[i] = 18'h08000;
    run_vector(0, 54'h2_ABCD, 16, 1'b1, 1'b0);
    total++;
    if (obus[0][40:0] !== 41'h4_0000_0000) begin
      bad++; $display("FAIL gapped_const got %h want %h", obus[0][40:0], 41'h4_0000_0000);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 128; i++) smp[i] = 18'h20000;
    run_vector(2, 54'h15_5555_5555_5555, 128, 1'b0, 1'b0);
    total++;
    if (obus[2][40:0] !== NORM_MAX) begin
      bad++; $display("FAIL sat_const got %h want %h", obus[2][40:0], NORM_MAX);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) smp[i] = 18'($urandom);
      smp[0] = 18'h20000;
      smp[1] = 18'h1FFFF;
      run_vector(0, {22'($urandom), 32'($urandom)}, 16, r[0], 1'b0);
    end
  endtask

  task automatic test_hold_and_ignore();
    din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 18'($urandom);
      tick();
      total += 2;
      if (obus[0] !== last_exp[0]) begin
        bad++; $display("FAIL hold_obus got %h want %h", obus[0], last_exp[0]);
      end
      if (bsy[0] !== 1'b0) begin
        bad++; $display("FAIL idle_busy got %b want 0", bsy[0]);
      end
    end
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) smp[i] = 18'(i * 3000 + 17);
    run_vector(1, 54'h12_3456_789A, 4, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) smp[i] = 18'($urandom);
    run_vector(0, 54'h0A_5A5A, 16, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    st[0] = 1'b1; wt_in = 54'h77;
    tick();
    st[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 18'h10000; din_valid = 1'b1;
      tick();
    end
    rst = 1'b1; st[0] = 1'b1;
    tick();
    rst = 1'b0; st[0] = 1'b0;
    repeat (16) tick();
    din_valid = 1'b0;
    repeat (4) tick();
    total += 2;
    if (obus[0] !== 95'd0) begin bad++; $display("FAIL rstmid_obus got %h want 0", obus[0]); end
    if (bsy[0] !== 1'b0)   begin bad++; $display("FAIL rstmid_busy got %b want 0", bsy[0]); end
    for (int i = 0; i < 16; i++) smp[i] = 18'h10000;
    run_vector(0, 54'h5, 16, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) smp[i] = 18'($urandom);
      run_vector(1, 54'(r + 100), 4, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_extreme();
    test_gapped();
    test_saturation();
    test_random();
    test_hold_and_ignore();
    test_reset_mid();
    test_back_to_back();
    repeat (5) tick();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL leftover got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
